// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage between EX/MEM and MEM/WB.
// Word-organised RAM with clocked full-word stores, combinational loads
// and an asynchronous clear of every word on reset.
module mem_stage #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [IDX_W-1:0] word_idx;

    // Byte offset and bits above the RAM span play no part in the access:
    // misaligned addresses round down and larger addresses alias.
    assign word_idx = addr[IDX_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

    // Next memory image: unchanged unless a store targets the indexed word.
    always_comb begin
        // NOTE: the default copy comes first so every word is assigned on
        // every path; without it this block would infer latches.
        mem_d = mem_q;
        if (mem_write) begin
            mem_d[word_idx] = write_data;
        end
    end

    // Memory register with asynchronous clear; reset also blocks any store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this memory is deliberately reset, word by word, so it is
            // built from flops rather than a RAM macro (which cannot clear).
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            mem_q <= mem_d;
        end
    end

    // Combinational load port; zero when no load is requested.
    always_comb begin
        read_data = 32'h0;
        if (mem_read) begin
            read_data = mem_q[word_idx];
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int total = 0;
    int bad   = 0;

    mem_stage #(.DEPTH(256), .IDX_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-edge store pulse; inputs change on the falling edge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        addr       = a;
        write_data = d;
        @(posedge clk);
        #1;
        mem_write  = 1'b0;
    endtask

    // Present a load away from the clock edge and compare read_data.
    task automatic do_load(input string name, input logic rd,
                           input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        mem_write = 1'b0;
        mem_read  = rd;
        addr      = a;
        #1;
        total++;
        if (read_data !== exp) begin
            bad++;
            $display("FAIL %s: read_data=%h expected=%h", name, read_data, exp);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr       = 32'h0;
        write_data = 32'h0;
        #1;
        total++;
        if (read_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_noread: read_data=%h expected=%h", read_data, 32'h0);
        end
        mem_read = 1'b1;
        addr     = 32'h8;
        #1;
        total++;
        if (read_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_read: read_data=%h expected=%h", read_data, 32'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        mem_read = 1'b0;
    endtask

    task automatic test_basic();
        do_store(32'h8, 32'd100);
        do_load("basic_read", 1'b1, 32'h8, 32'd100);
        do_load("basic_noread", 1'b0, 32'h8, 32'h0);
    endtask

    task automatic test_two_locations();
        do_store(32'h10, 32'd55);
        do_load("loc16", 1'b1, 32'h10, 32'd55);
        do_load("loc8_kept", 1'b1, 32'h8, 32'd100);
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        addr       = 32'h4;
        write_data = 32'hDEADBEEF;
        #1;
        total++;
        if (read_data !== 32'h0) begin
            bad++;
            $display("FAIL rw_before: read_data=%h expected=%h", read_data, 32'h0);
        end
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        #1;
        total++;
        if (read_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rw_after: read_data=%h expected=%h", read_data, 32'hDEADBEEF);
        end
    endtask

    task automatic test_alias();
        do_store(32'h400, 32'h12345678);
        do_load("alias_0", 1'b1, 32'h0, 32'h12345678);
        do_load("alias_403", 1'b1, 32'h403, 32'h12345678);
        do_load("alias_401", 1'b1, 32'h401, 32'h12345678);
    endtask

    task automatic test_reset_mid();
        do_store(32'hC, 32'd7);
        do_load("pre_reset", 1'b1, 32'hC, 32'd7);
        // Pending store while reset is asserted between edges.
        @(negedge clk);
        mem_write  = 1'b1;
        mem_read   = 1'b1;
        addr       = 32'hC;
        write_data = 32'hA5A5A5A5;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (read_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_immediate: read_data=%h expected=%h", read_data, 32'h0);
        end
        @(posedge clk);
        #1;
        total++;
        if (read_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_blocks_store: read_data=%h expected=%h", read_data, 32'h0);
        end
        @(negedge clk);
        mem_write = 1'b0;
        rst_n     = 1'b1;
        do_load("post_reset_12", 1'b1, 32'hC, 32'h0);
        do_load("post_reset_8", 1'b1, 32'h8, 32'h0);
    endtask

    task automatic test_write_disable();
        do_store(32'h8, 32'd100);
        @(negedge clk);
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        addr       = 32'h8;
        write_data = 32'hFFFFFFFF;
        repeat (4) @(posedge clk);
        do_load("write_disable", 1'b1, 32'h8, 32'd100);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_locations();
        test_same_cycle();
        test_alias();
        test_reset_mid();
        test_write_disable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
